// File: rtl/spm_master_pkg.sv
// ---------------------------------------------------------------------------
// spm_master_pkg
// Shared definitions for the single-port-memory burst master.
//   - state_t and its four state constants (IDLE, WRITE, READ, DONE)
//   - RD_FIFO_DEPTH : number of read beats that may be buffered or in flight
//   - CREDIT_W      : width that can hold 0..RD_FIFO_DEPTH (FIFO count and
//                     the read credit sum)
//   - PTR_W         : FIFO pointer width
// ---------------------------------------------------------------------------
package spm_master_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int RD_FIFO_DEPTH = 4;
  localparam int CREDIT_W      = $clog2(RD_FIFO_DEPTH + 1);
  localparam int PTR_W         = $clog2(RD_FIFO_DEPTH);

endpackage

// File: rtl/spm_rd_fifo.sv
// ---------------------------------------------------------------------------
// spm_rd_fifo
// Small synchronous FIFO that buffers read beats between the memory capture
// point and the read-data stream.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset (empties the FIFO)
//   i_push       write i_push_data into the tail
//   i_push_data  data captured from the memory
//   i_pop        remove the head entry (only honoured when not empty)
//   o_pop_data   head entry, stable until popped
//   o_empty      no entries held
//   o_count      number of entries held (0..RD_FIFO_DEPTH)
// ---------------------------------------------------------------------------
module spm_rd_fifo
  import spm_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic                  o_empty,
  output logic [CREDIT_W-1:0]   o_count
);

  logic [DATA_WIDTH-1:0] r_mem [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CREDIT_W-1:0]   r_count;

  logic w_full;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full    = (r_count == CREDIT_W'(RD_FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  // The master never pushes into a full FIFO, but a push alongside a pop
  // is still accepted so a full FIFO can stream at full rate.
  assign w_push_ok = i_push && (!w_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Storage array; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CREDIT_W'(1);
        2'b01:   r_count <= r_count - CREDIT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spm_burst_master.sv
// ---------------------------------------------------------------------------
// spm_burst_master
// Burst engine driving a single-port synchronous memory. One command at a
// time; write beats arrive on a valid/ready stream and are written one per
// cycle, read beats are fetched ahead into a small FIFO and streamed out.
// Ports:
//   i_clk, i_rst_n              clock / asynchronous active-low reset
//   i_cmd_valid, o_cmd_ready    command handshake (ready only when idle)
//   i_cmd_write                 1 = write burst, 0 = read burst
//   i_cmd_addr                  burst base address
//   i_cmd_len                   beats minus one
//   i_wdata_valid, o_wdata_ready, i_wdata   write beat stream
//   o_rdata_valid, i_rdata_ready, o_rdata   read beat stream
//   o_busy                      engine not idle
//   o_done                      one-cycle pulse when a burst completes
//   o_mem_wr_en, o_mem_rd_en, o_mem_address, o_mem_wr_data   memory port
//   i_mem_rd_data               memory read data (valid the cycle after rd_en)
// ---------------------------------------------------------------------------
module spm_burst_master
  import spm_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic                  i_wdata_valid,
  output logic                  o_wdata_ready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_rdata_valid,
  input  logic                  i_rdata_ready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_wr_en,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data
);

  // One extra bit so a full 2^LEN_WIDTH beat count fits.
  localparam int BEAT_W = LEN_WIDTH + 1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BEAT_W-1:0]     r_issue_left;
  logic [BEAT_W-1:0]     r_pop_left;
  logic                  r_mem_wr_en;
  logic                  r_mem_rd_en;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_wr_data;
  logic                  r_rd_pipe;

  logic                  w_fifo_empty;
  logic [CREDIT_W-1:0]   w_fifo_count;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic                  w_rbeat_fire;
  logic [CREDIT_W-1:0]   w_credit_used;
  logic                  w_can_issue;

  assign o_cmd_ready   = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_wdata_ready = (r_state == ST_WRITE);
  assign o_rdata_valid = (r_state == ST_READ) && !w_fifo_empty;
  assign o_rdata       = w_fifo_data;

  assign o_mem_wr_en   = r_mem_wr_en;
  assign o_mem_rd_en   = r_mem_rd_en;
  assign o_mem_address = r_mem_address;
  assign o_mem_wr_data = r_mem_wr_data;

  assign w_rbeat_fire = o_rdata_valid && i_rdata_ready;

  // Every entry already buffered plus every read still on its way from the
  // memory (issued last cycle, or returning this cycle) holds a FIFO slot.
  // A pop in the same cycle is deliberately not credited: it costs nothing
  // at full throughput and keeps the FIFO provably overflow-free.
  assign w_credit_used = w_fifo_count + CREDIT_W'(r_mem_rd_en) + CREDIT_W'(r_rd_pipe);
  assign w_can_issue   = (r_state == ST_READ) && (r_issue_left != '0) &&
                         (w_credit_used < CREDIT_W'(RD_FIFO_DEPTH));

  // Control state and burst counters. r_issue_left counts beats still to be
  // accepted in a write burst, or reads still to be issued in a read burst.
  // The first read is issued directly from the command handshake so data
  // reaches the stream three cycles after the command.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_pop_left   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            if (i_cmd_write) begin
              r_state      <= ST_WRITE;
              r_addr       <= i_cmd_addr;
              r_issue_left <= BEAT_W'(i_cmd_len) + BEAT_W'(1);
            end else begin
              r_state      <= ST_READ;
              r_addr       <= i_cmd_addr + ADDR_WIDTH'(1);
              r_issue_left <= BEAT_W'(i_cmd_len);
              r_pop_left   <= BEAT_W'(i_cmd_len) + BEAT_W'(1);
            end
          end
        end
        ST_WRITE: begin
          if (i_wdata_valid) begin
            r_addr       <= r_addr + ADDR_WIDTH'(1);
            r_issue_left <= r_issue_left - BEAT_W'(1);
            if (r_issue_left == BEAT_W'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_READ: begin
          if (w_can_issue) begin
            r_addr       <= r_addr + ADDR_WIDTH'(1);
            r_issue_left <= r_issue_left - BEAT_W'(1);
          end
          if (w_rbeat_fire) begin
            r_pop_left <= r_pop_left - BEAT_W'(1);
            if (r_pop_left == BEAT_W'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered memory port. Enables default low every cycle; address and
  // write data only change when an access is issued, so they hold between
  // accesses. Write and read enables come from different states and can
  // never be high together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_wr_en   <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wr_data <= '0;
    end else begin
      r_mem_wr_en <= 1'b0;
      r_mem_rd_en <= 1'b0;
      if ((r_state == ST_IDLE) && i_cmd_valid && !i_cmd_write) begin
        r_mem_rd_en   <= 1'b1;
        r_mem_address <= i_cmd_addr;
      end else if ((r_state == ST_WRITE) && i_wdata_valid) begin
        r_mem_wr_en   <= 1'b1;
        r_mem_address <= r_addr;
        r_mem_wr_data <= i_wdata;
      end else if (w_can_issue) begin
        r_mem_rd_en   <= 1'b1;
        r_mem_address <= r_addr;
      end
    end
  end

  // One-bit pipe marking the cycle in which the memory returns valid data;
  // i_mem_rd_data is looked at in no other cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pipe <= 1'b0;
    end else begin
      r_rd_pipe <= r_mem_rd_en;
    end
  end

  spm_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (r_rd_pipe),
    .i_push_data (i_mem_rd_data),
    .i_pop       (w_rbeat_fire),
    .o_pop_data  (w_fifo_data),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

endmodule

// File: tb/tb_spm_burst_master.sv
// ---------------------------------------------------------------------------
// tb_spm_burst_master
// Bench for spm_burst_master: a memory model on the DUT's memory port, a
// transaction-level reference (expected memory writes and expected read
// beats derived from accepted commands and beats), and a per-cycle monitor.
// ---------------------------------------------------------------------------
module tb_spm_burst_master;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic       i_cmd_write = 1'b0;
  logic [7:0] i_cmd_addr = '0;
  logic [3:0] i_cmd_len = '0;
  logic       i_wdata_valid = 1'b0;
  logic       o_wdata_ready;
  logic [7:0] i_wdata = '0;
  logic       o_rdata_valid;
  logic       i_rdata_ready = 1'b0;
  logic [7:0] o_rdata;
  logic       o_busy;
  logic       o_done;
  logic       o_mem_wr_en;
  logic       o_mem_rd_en;
  logic [7:0] o_mem_address;
  logic [7:0] o_mem_wr_data;
  logic [7:0] i_mem_rd_data;

  spm_burst_master #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .LEN_WIDTH  (4)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_write   (i_cmd_write),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_len     (i_cmd_len),
    .i_wdata_valid (i_wdata_valid),
    .o_wdata_ready (o_wdata_ready),
    .i_wdata       (i_wdata),
    .o_rdata_valid (o_rdata_valid),
    .i_rdata_ready (i_rdata_ready),
    .o_rdata       (o_rdata),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_address (o_mem_address),
    .o_mem_wr_data (o_mem_wr_data),
    .i_mem_rd_data (i_mem_rd_data)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;

  always @(posedge i_clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Untouched memory locations read back a fixed function of the address.
  function automatic logic [7:0] initVal(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // Memory attached to the DUT: data valid the cycle after rd_en, garbage
  // otherwise.
  logic [7:0] physMem [256];
  bit         physWr  [256] = '{default: 1'b0};
  logic [7:0] memRdData = '0;
  assign i_mem_rd_data = memRdData;

  always @(posedge i_clk) begin
    if (o_mem_wr_en) begin
      physMem[o_mem_address] <= o_mem_wr_data;
      physWr[o_mem_address]  <= 1'b1;
    end
    if (o_mem_rd_en) begin
      memRdData <= physWr[o_mem_address] ? physMem[o_mem_address] : initVal(o_mem_address);
    end else begin
      memRdData <= 8'($urandom);
    end
  end

  function automatic logic [7:0] physRead(input logic [7:0] a);
    return physWr[a] ? physMem[a] : initVal(a);
  endfunction

  // Reference model state, owned by the monitor.
  logic [7:0]  modelMem [256];
  bit          modelWr  [256] = '{default: 1'b0};
  logic [15:0] expWr [$];
  logic [7:0]  expRd [$];
  logic [7:0]  gotRd [$];
  logic [15:0] monE;
  logic [7:0]  monA;
  logic [7:0]  wrAddr = '0;
  logic [7:0]  stickyData = '0;
  int          wrLeft = 0;
  int          rdLeft = 0;
  int          rdBeats = 0;
  int          outstanding = 0;
  int          issuedBurst = 0;
  int          rdCmdCycle = 0;
  int          doneCount = 0;
  bit          inWrite = 0;
  bit          inRead = 0;
  bit          pendWr = 0;
  bit          doneExp = 0;
  bit          firstSeen = 1;
  bit          stickyValid = 0;

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      expWr.delete();
      expRd.delete();
      inWrite = 0; inRead = 0; pendWr = 0; doneExp = 0;
      outstanding = 0; wrLeft = 0; rdLeft = 0;
      firstSeen = 1; stickyValid = 0;
    end else begin
      checkOutput("done_timing", o_done, doneExp);
      doneExp = 0;
      if (o_done) doneCount++;
      checkOutput("wr_en_timing", o_mem_wr_en, pendWr);
      if (pendWr && o_mem_wr_en && expWr.size() > 0) begin
        monE = expWr.pop_front();
        checkOutput("wr_addr", o_mem_address, monE[15:8]);
        checkOutput("wr_data", o_mem_wr_data, monE[7:0]);
      end
      pendWr = 0;
      checkOutput("en_exclusive", o_mem_wr_en & o_mem_rd_en, 0);
      checkOutput("ready_vs_busy", o_cmd_ready, !o_busy);
      checkOutput("wdata_ready_scope", o_wdata_ready, inWrite);
      if (o_mem_rd_en) begin
        checkOutput("rd_en_scope", inRead, 1);
        issuedBurst++;
        outstanding++;
      end
      checkOutput("outstanding_le4", outstanding <= 4, 1);
      if (stickyValid) begin
        checkOutput("rdata_hold_valid", o_rdata_valid, 1);
        checkOutput("rdata_hold_data", o_rdata, stickyData);
      end
      stickyValid = o_rdata_valid && !i_rdata_ready;
      stickyData  = o_rdata;
      if (o_rdata_valid) checkOutput("rdata_valid_scope", inRead, 1);
      if (inRead && !firstSeen && o_rdata_valid) begin
        firstSeen = 1;
        checkOutput("rd_latency", cycleCnt - rdCmdCycle, 3);
      end
      if (o_rdata_valid && i_rdata_ready) begin
        checkOutput("rd_beat_expected", expRd.size() > 0, 1);
        if (expRd.size() > 0) begin
          monA = expRd.pop_front();
          checkOutput("rd_data", o_rdata, monA);
        end
        gotRd.push_back(o_rdata);
        outstanding--;
        rdLeft--;
        if (rdLeft == 0 && inRead) begin
          inRead = 0;
          doneExp = 1;
          checkOutput("rd_issue_total", issuedBurst, rdBeats);
        end
      end
      if (o_wdata_ready && i_wdata_valid) begin
        expWr.push_back({wrAddr, i_wdata});
        modelMem[wrAddr] = i_wdata;
        modelWr[wrAddr]  = 1'b1;
        wrAddr = wrAddr + 8'd1;
        pendWr = 1;
        wrLeft--;
        if (wrLeft == 0) begin
          inWrite = 0;
          doneExp = 1;
        end
      end
      if (i_cmd_valid && o_cmd_ready) begin
        if (i_cmd_write) begin
          inWrite = 1;
          wrAddr  = i_cmd_addr;
          wrLeft  = int'(i_cmd_len) + 1;
        end else begin
          inRead      = 1;
          rdLeft      = int'(i_cmd_len) + 1;
          rdBeats     = rdLeft;
          issuedBurst = 0;
          firstSeen   = 0;
          rdCmdCycle  = cycleCnt;
          for (int i = 0; i < rdLeft; i++) begin
            monA = i_cmd_addr + 8'(i);
            expRd.push_back(modelWr[monA] ? modelMem[monA] : initVal(monA));
          end
        end
      end
    end
  end

  logic [7:0] wrData [16];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Offer one command and hold it until the DUT takes it.
  task automatic applyStimulus(input bit isWrite, input logic [7:0] addr,
                               input logic [3:0] len);
    int guard = 0;
    while (!o_cmd_ready && guard < 50) begin
      step();
      guard++;
    end
    checkOutput("cmd_ready_wait", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_write = isWrite;
    i_cmd_addr  = addr;
    i_cmd_len   = len;
    step();
    i_cmd_valid = 1'b0;
  endtask

  // gapMode: 0 = every cycle, 1 = alternate 1,0,1,0, 2 = random.
  task automatic driveWrite(input int nBeats, input int gapMode, input bit stray);
    int sent = 0;
    int guard = 0;
    int start = doneCount;
    bit v;
    while (sent < nBeats && guard < 300) begin
      case (gapMode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      i_wdata_valid = v;
      i_wdata       = wrData[sent];
      i_cmd_valid   = stray;
      i_cmd_write   = 1'b0;
      i_cmd_addr    = 8'h77;
      if (v && o_wdata_ready) sent++;
      step();
      guard++;
    end
    i_wdata_valid = 1'b0;
    i_cmd_valid   = 1'b0;
    guard = 0;
    while (doneCount == start && guard < 20) begin
      step();
      guard++;
    end
    step();
    step();
    checkOutput("write_done_once", doneCount - start, 1);
  endtask

  // readyMode: 0 = always ready, 1 = low 10 cycles then high, 2 = random.
  task automatic driveRead(input int nBeats, input int readyMode);
    int k = 0;
    int start = doneCount;
    while (doneCount == start && k < 400) begin
      if (readyMode == 1 && k == 10 && nBeats >= 4)
        checkOutput("stall_issue_count", issuedBurst, 4);
      case (readyMode)
        0:       i_rdata_ready = 1'b1;
        1:       i_rdata_ready = (k >= 10);
        default: i_rdata_ready = 1'($urandom_range(0, 1));
      endcase
      i_wdata_valid = 1'($urandom_range(0, 1));
      i_wdata       = 8'($urandom);
      step();
      k++;
    end
    i_rdata_ready = 1'b0;
    i_wdata_valid = 1'b0;
    step();
    step();
    checkOutput("read_done_once", doneCount - start, 1);
  endtask

  int base;

  initial begin
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("rst_cmd_ready", o_cmd_ready, 1);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_wdata_ready", o_wdata_ready, 0);
    checkOutput("rst_rdata_valid", o_rdata_valid, 0);
    checkOutput("rst_rdata", o_rdata, 0);
    checkOutput("rst_mem_en", {o_mem_wr_en, o_mem_rd_en}, 0);
    checkOutput("rst_mem_addr", o_mem_address, 0);
    checkOutput("rst_mem_wdata", o_mem_wr_data, 0);
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    step();

    $display("[TB] write burst 0x10 len 3");
    for (int i = 0; i < 4; i++) wrData[i] = 8'hA0 + 8'(i);
    applyStimulus(1'b1, 8'h10, 4'd3);
    driveWrite(4, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      checkOutput("t1_mem", physRead(8'h10 + 8'(i)), 8'hA0 + 8'(i));

    $display("[TB] read burst 0x10 len 3");
    base = gotRd.size();
    applyStimulus(1'b0, 8'h10, 4'd3);
    driveRead(4, 0);
    checkOutput("t2_count", gotRd.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < gotRd.size())
        checkOutput("t2_data", gotRd[base + i], 8'hA0 + 8'(i));

    $display("[TB] read burst 0x10 len 7 with stall");
    base = gotRd.size();
    applyStimulus(1'b0, 8'h10, 4'd7);
    driveRead(8, 1);
    checkOutput("t3_count", gotRd.size() - base, 8);
    if (base + 4 < gotRd.size()) checkOutput("t3_beat4", gotRd[base + 4], 8'h4E);

    $display("[TB] wrap write 0xFE len 3 and readback");
    wrData[0] = 8'h11; wrData[1] = 8'h22; wrData[2] = 8'h33; wrData[3] = 8'h44;
    applyStimulus(1'b1, 8'hFE, 4'd3);
    driveWrite(4, 0, 1'b0);
    checkOutput("t4_mem_fe", physRead(8'hFE), 8'h11);
    checkOutput("t4_mem_ff", physRead(8'hFF), 8'h22);
    checkOutput("t4_mem_00", physRead(8'h00), 8'h33);
    checkOutput("t4_mem_01", physRead(8'h01), 8'h44);
    base = gotRd.size();
    applyStimulus(1'b0, 8'hFE, 4'd3);
    driveRead(4, 0);
    checkOutput("t4_count", gotRd.size() - base, 4);
    if (base + 3 < gotRd.size()) checkOutput("t4_beat3", gotRd[base + 3], 8'h44);

    $display("[TB] gapped write with stray command");
    for (int i = 0; i < 4; i++) wrData[i] = 8'($urandom);
    applyStimulus(1'b1, 8'h30, 4'd3);
    driveWrite(4, 1, 1'b1);

    $display("[TB] reset during read burst");
    base = doneCount;
    applyStimulus(1'b0, 8'h10, 4'd7);
    i_rdata_ready = 1'b1;
    repeat (4) step();
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("midrst_mem_en", {o_mem_wr_en, o_mem_rd_en}, 0);
    checkOutput("midrst_rvalid", o_rdata_valid, 0);
    checkOutput("midrst_done", o_done, 0);
    checkOutput("midrst_ready", o_cmd_ready, 1);
    i_rdata_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    step();
    checkOutput("midrst_no_done", doneCount - base, 0);
    base = gotRd.size();
    applyStimulus(1'b0, 8'h10, 4'd3);
    driveRead(4, 0);
    checkOutput("t6_count", gotRd.size() - base, 4);
    if (base < gotRd.size()) checkOutput("t6_beat0", gotRd[base], 8'hA0);

    $display("[TB] random bursts");
    for (int n = 0; n < 24; n++) begin
      logic [7:0] ra;
      logic [3:0] rl;
      ra = 8'($urandom);
      rl = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) wrData[i] = 8'($urandom);
        applyStimulus(1'b1, ra, rl);
        driveWrite(int'(rl) + 1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(1'b0, ra, rl);
        driveRead(int'(rl) + 1, $urandom_range(0, 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
